// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_if : CPU fetch/data request buses plus the shared memory port  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ready;
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;
  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 m_ack;

  // Arbiter side
  modport slave (
    input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata
  );

  // CPU and memory side
  modport master (
    output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_readM, m_writeM, m_address, m_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter : data-over-fetch arbiter for one multi-cycle memory port.     |
// | Optional MEM_ARBITER_PERF_EN adds grant/conflict counters.                 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  wire logic     Clk,
  input  wire logic     Reset_N,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [WORD_SIZE-1:0] perf_i_grants,
  output logic [WORD_SIZE-1:0] perf_d_grants,
  output logic [WORD_SIZE-1:0] perf_conflicts
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t               r_state, w_state;
  logic                 r_m_read, w_m_read;
  logic                 r_m_write, w_m_write;
  logic                 r_i_ready, w_i_ready;
  logic                 r_d_ready, w_d_ready;
  logic [WORD_SIZE-1:0] r_m_addr, w_m_addr;
  logic [WORD_SIZE-1:0] r_m_wdata, w_m_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata, w_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata, w_d_rdata;

  // A requester whose ready is high this cycle still holds its request; mask it.
  logic w_d_elig, w_i_elig;
  assign w_d_elig = (bus.d_readM | bus.d_writeM) & ~r_d_ready;
  assign w_i_elig = bus.i_readM & ~r_i_ready;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state   <= IDLE;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state   <= w_state;
      r_m_read  <= w_m_read;
      r_m_write <= w_m_write;
      r_i_ready <= w_i_ready;
      r_d_ready <= w_d_ready;
      r_m_addr  <= w_m_addr;
      r_m_wdata <= w_m_wdata;
      r_i_rdata <= w_i_rdata;
      r_d_rdata <= w_d_rdata;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_m_read  = r_m_read;
    w_m_write = r_m_write;
    w_m_addr  = r_m_addr;
    w_m_wdata = r_m_wdata;
    w_i_rdata = r_i_rdata;
    w_d_rdata = r_d_rdata;
    w_i_ready = 1'b0;
    w_d_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_elig) begin
          w_state   = D_BUSY;
          w_m_addr  = bus.d_address;
          w_m_wdata = bus.d_wdata;
          w_m_write = bus.d_writeM;
          w_m_read  = ~bus.d_writeM;
        end else if (w_i_elig) begin
          w_state   = I_BUSY;
          w_m_addr  = bus.i_address;
          w_m_write = 1'b0;
          w_m_read  = 1'b1;
        end
      end
      I_BUSY: begin
        if (bus.m_ack) begin
          w_state   = IDLE;
          w_i_rdata = bus.m_rdata;
          w_i_ready = 1'b1;
          w_m_read  = 1'b0;
          w_m_write = 1'b0;
        end
      end
      D_BUSY: begin
        if (bus.m_ack) begin
          w_state   = IDLE;
          if (r_m_read) w_d_rdata = bus.m_rdata;
          w_d_ready = 1'b1;
          w_m_read  = 1'b0;
          w_m_write = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.m_readM   = r_m_read;
  assign bus.m_writeM  = r_m_write;
  assign bus.m_address = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_rdata   = r_d_rdata;

`ifdef MEM_ARBITER_PERF_EN
  logic [WORD_SIZE-1:0] r_perf_i, r_perf_d, r_perf_c;
  logic                 w_idle;
  assign w_idle = (r_state == IDLE);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_perf_i <= '0;
      r_perf_d <= '0;
      r_perf_c <= '0;
    end else begin
      if (w_idle && w_d_elig)              r_perf_d <= r_perf_d + 1'b1;
      if (w_idle && !w_d_elig && w_i_elig) r_perf_i <= r_perf_i + 1'b1;
      if (w_idle && w_d_elig && w_i_elig)  r_perf_c <= r_perf_c + 1'b1;
    end
  end

  assign perf_i_grants  = r_perf_i;
  assign perf_d_grants  = r_perf_d;
  assign perf_conflicts = r_perf_c;
`endif

endmodule
`default_nettype wire
